// File: rtl/uc_capture_pkg.sv
// Shared types and constants for the triggered sample capture block.
package uc_capture_pkg;

  localparam int DEFAULT_DW = 16;
  localparam int DEFAULT_AW = 10;

  // Trigger mode encodings; the fourth code falls back to immediate.
  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/uc_capture_ram.sv
// Capture buffer: one write port, one registered read-first read port.
// The array itself has no reset so it maps onto block RAM.
module uc_capture_ram
  import uc_capture_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port; kept out of the reset domain so the array stays resetless.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register; sees the pre-write word on a same-address collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uc_sample_capture.sv
// Triggered capture of the decimated baseband stream into RAM for CPU readback.
// Holds the capture FSM, trigger comparator, previous-sample register and counter.
module uc_sample_capture
  import uc_capture_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          arm,
  input  logic          abort,
  input  logic [1:0]    trig_mode,
  input  logic [DW-1:0] trig_level,
  input  logic [AW:0]   num_samples,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [AW:0]          count_q, count_d;
  logic [AW:0]          target_q, target_d;
  logic [1:0]           mode_q, mode_d;
  logic signed [DW-1:0] level_q, level_d;
  logic signed [DW-1:0] prev_q, prev_d;
  logic                 prev_valid_q, prev_valid_d;
  logic                 busy_q, done_q;

  logic signed [DW-1:0] cur;
  logic [AW:0]          count_inc;
  logic [AW:0]          target_clamped;
  logic                 trig_hit;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;

  assign cur            = s_data;
  assign count_inc      = count_q + CNT_ONE;
  assign target_clamped = ((num_samples == '0) || (num_samples > DEPTH)) ? DEPTH : num_samples;

  // Signed trigger test of the incoming sample against the latched threshold.
  always_comb begin
    trig_hit = 1'b1;
    case (mode_q)
      TRIG_RISE: trig_hit = prev_valid_q && (prev_q < level_q) && (cur >= level_q);
      TRIG_FALL: trig_hit = prev_valid_q && (prev_q > level_q) && (cur <= level_q);
      default:   trig_hit = 1'b1;
    endcase
  end

  // Next-state, counter and RAM write decode; abort overrides everything else.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    target_d     = target_q;
    mode_d       = mode_q;
    level_d      = level_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_en        = 1'b0;
    wr_addr      = '0;
    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d      = ST_ARMED;
            count_d      = '0;
            prev_valid_d = 1'b0;
            target_d     = target_clamped;
            mode_d       = trig_mode;
            level_d      = trig_level;
          end
        end
        ST_ARMED: begin
          if (s_valid) begin
            prev_d       = cur;
            prev_valid_d = 1'b1;
            if (trig_hit) begin
              wr_en   = 1'b1;
              wr_addr = '0;
              count_d = CNT_ONE;
              state_d = (target_q == CNT_ONE) ? ST_DONE : ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (s_valid) begin
            wr_en   = 1'b1;
            wr_addr = count_q[AW-1:0];
            count_d = count_inc;
            if (count_inc == target_q) begin
              state_d = ST_DONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, latched configuration and status flags; flags follow the next state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      target_q     <= '0;
      mode_q       <= TRIG_IMM;
      level_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      target_q     <= target_d;
      mode_q       <= mode_d;
      level_q      <= level_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      busy_q       <= (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  uc_capture_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_i   (sys_clk),
    .rst_ni  (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (s_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: doc/uc_sample_capture.md
Name: uc_sample_capture

Overview:
- Triggered capture buffer that records the decimated baseband stream into on-chip RAM for CPU readback.
- Sits directly downstream of the down-conversion CORDIC and decimating filter. Consumes the filter output word and its ce_out strobe.
- Arming, trigger configuration and readback are driven by CPU-side CSRs.

Parameters:
DW, 16, sample width (signed two's complement)
AW, 10, RAM address width; buffer depth = 2**AW samples

Ports:
sys_clk  in  1  system clock; single clock domain
rst_n  in  1  asynchronous active-low reset
s_data  in  DW  signed sample from decimating filter
s_valid  in  1  sample strobe (filter ce_out); one sample per high cycle
arm  in  1  single-cycle pulse; start a capture
abort  in  1  single-cycle pulse; cancel any capture
trig_mode  in  2  0 = immediate, 1 = rising threshold, 2 = falling threshold, 3 = reserved (treated as immediate)
trig_level  in  DW  signed threshold
num_samples  in  AW+1  samples to store; 0 or >2**AW means 2**AW; sampled at arm
rd_addr  in  AW  CPU read address
rd_data  out  DW  RAM word at rd_addr, one-cycle latency
busy  out  1  high in ARMED or CAPTURE
done  out  1  high in DONE
count  out  AW+1  samples written in current/last capture

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE
  - busy = 0, done = 0, count = 0, rd_data = 0
  - prev_valid = 0, internal target length = 0
  - RAM contents are not reset.
- States: IDLE, ARMED, CAPTURE, DONE. busy and done are registered decodes of the state.
- IDLE or DONE, arm=1:
  - go to ARMED next cycle
  - count <= 0, prev_valid <= 0
  - latch num_samples (clamped as above) into target N
  - latch trig_mode and trig_level; later CSR changes do not affect the running capture
- arm while ARMED or CAPTURE: ignored.
- abort=1 in any state:
  - go to IDLE next cycle, count <= 0
  - abort has priority over arm and over any same-cycle write
- ARMED, on each s_valid:
  - Evaluate trigger on the current sample cur:
    - immediate: always true
    - rising: prev_valid && prev < L && cur >= L
    - falling: prev_valid && prev > L && cur <= L
    - Comparisons are signed.
  - Then update prev <= cur, prev_valid <= 1.
  - On trigger: write cur to RAM[0], count <= 1; go to CAPTURE, or to DONE if N == 1.
  - The first sample after arming can never fire a threshold trigger.
- CAPTURE, on each s_valid:
  - write cur to RAM[count[AW-1:0]], count <= count+1
  - when count+1 == N, go to DONE in the same edge
- Gaps in s_valid stall capture with no writes.
- DONE: hold count, done = 1 until the next arm or abort.
- Capture from trigger to DONE therefore spans exactly N valid samples. DONE asserts the cycle after the Nth write.
- Read port:
  - synchronous; rd_data registered on every clock, valid the cycle after rd_addr
  - allowed in any state
  - same-cycle write/read to the same address returns the old word (read-first)
- No wrap-around: the write address never exceeds N-1 ≤ 2**AW-1.
- Reset mid-capture: immediate IDLE with outputs at reset values. RAM keeps partial data; count reads 0.

Decomposition:
- Package uc_capture_pkg:
  - state enum (IDLE, ARMED, CAPTURE, DONE)
  - trig_mode constants (TRIG_IMM, TRIG_RISE, TRIG_FALL)
  - default DW/AW localparams
- Sub-module uc_capture_ram: simple dual-port RAM, one write port, one registered read-first read port, 2**AW x DW, no reset on the array, inferable as block RAM.
- Top module holds the FSM, trigger comparator, prev register and counter.

Test Plan:
- Immediate capture:
  - Stimulus: trig_mode=0, N=4, arm; then s_valid samples 1,2,3,4,5 with 1-cycle gaps.
  - Response: done rises the cycle after sample 4 is written; count=4; rd_addr 0..3 returns 1,2,3,4 one cycle later; sample 5 is not stored.
- Rising trigger:
  - Stimulus: mode=1, L=100, N=2; samples 120,50,90,120,130,80.
  - Response: the first 120 does not trigger (no prev). RAM[0..1] = 120,130; done=1; count=2.
- Falling trigger, signed:
  - Stimulus: mode=2, L=-10, N=3; samples 5,0,-10,-20,7.
  - Response: trigger on -10; RAM[0..2] = -10,-20,7.
- Abort and arm:
  - Stimulus: abort after 2 of N=8 stored; then arm and abort in the same cycle.
  - Response: IDLE next cycle, busy=0, done=0, count=0. The same-cycle arm+abort stays IDLE.
- Full depth:
  - Stimulus: N=0 with AW=4, immediate mode; 20 samples 0..19.
  - Response: count=16; RAM[15]=15; done=1; no write to RAM[0] after sample 16.
- Reset mid-capture:
  - Stimulus: rst_n low asynchronously during CAPTURE; then release.
  - Response: busy, done, count and rd_data go to 0 immediately. A following arm captures normally.
